// File: rtl/midi_pkg.sv
// Shared constants, state encodings and helpers for the MIDI IN front end.
package midi_pkg;

   localparam logic [7:0] NOTE_OFF = 8'h80;
   localparam logic [7:0] NOTE_ON  = 8'h90;
   localparam logic [7:0] CTRL     = 8'hB0;
   localparam logic [7:0] PROG     = 8'hC0;
   localparam logic [7:0] CHPRESS  = 8'hD0;
   localparam logic [7:0] SYS      = 8'hF0;
   localparam logic [7:0] RT_MIN   = 8'hF8;

   typedef enum logic [2:0] {
      U_IDLE,
      U_START,
      U_DATA,
      U_STOP,
      U_BREAK
   } uart_state_e;

   typedef enum logic [1:0] {
      P_WAIT_STATUS,
      P_WAIT_D1,
      P_WAIT_D2
   } parse_state_e;

   function automatic int unsigned bit_clks(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

   // Counter never narrower than 11 bits so default rates fit with margin.
   function automatic int unsigned cnt_width(input int unsigned bc);
      return ($clog2(bc) > 11) ? $clog2(bc) : 11;
   endfunction

   function automatic logic is_one_data(input logic [7:0] st);
      return (st[7:4] == PROG[7:4]) || (st[7:4] == CHPRESS[7:4]);
   endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI RX deserialiser: 2-FF synchroniser plus start/data/stop UART FSM.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int unsigned BIT_CLKS = 1600
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       err_o
);

   localparam int unsigned CW = cnt_width(BIT_CLKS);
   localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CLKS / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CLKS - 1);

   logic          sync1_q, sync2_q;
   uart_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          tick;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= U_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      tick    = (cnt_q == '0);
      unique case (state_q)
         U_IDLE: begin
            if (!sync2_q) begin
               state_d = U_START;
               cnt_d   = HALF_M1;
            end
         end
         U_START: begin
            if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else if (sync2_q) begin
               state_d = U_IDLE;
            end else begin
               state_d = U_DATA;
               cnt_d   = FULL_M1;
               idx_d   = '0;
            end
         end
         U_DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               sh_d  = {sync2_q, sh_q[7:1]};
               cnt_d = FULL_M1;
               if (idx_q == 3'd7) state_d = U_STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         U_STOP: begin
            if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else if (sync2_q) begin
               valid_d = 1'b1;
               state_d = U_IDLE;
            end else begin
               err_d   = 1'b1;
               state_d = U_BREAK;
            end
         end
         U_BREAK: begin
            if (sync2_q) state_d = U_IDLE;
         end
         default: state_d = U_IDLE;
      endcase
   end

   always_comb begin
      byte_o  = sh_q;
      valid_o = valid_q;
      err_o   = err_q;
   end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI IN front end: UART receive plus channel-message parser with running status.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned BAUD    = 31250,
   parameter bit          OMNI    = 1'b1,
   parameter logic [3:0]  CHANNEL = 4'd0
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        MIDI_RX,
   output logic [23:0] MIDI_MSG,
   output logic        MIDI_MSG_RDY,
   output logic        RX_ERR
);

   localparam int unsigned BIT_CLKS = bit_clks(CLK_HZ, BAUD);

   logic [7:0]   rx_byte;
   logic         rx_valid;
   logic         rx_err;

   parse_state_e state_q, state_d;
   logic [7:0]   rs_q, rs_d;
   logic         rs_vld_q, rs_vld_d;
   logic [7:0]   d1_q, d1_d;
   logic [23:0]  msg_q, msg_d;
   logic         rdy_q, rdy_d;
   logic         cmpl;
   logic [23:0]  cmpl_msg;

   midi_uart_rx #(
      .BIT_CLKS(BIT_CLKS)
   ) u_rx (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .rx_i   (MIDI_RX),
      .byte_o (rx_byte),
      .valid_o(rx_valid),
      .err_o  (rx_err)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= P_WAIT_STATUS;
         rs_q     <= '0;
         rs_vld_q <= 1'b0;
         d1_q     <= '0;
         msg_q    <= '0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rs_q     <= rs_d;
         rs_vld_q <= rs_vld_d;
         d1_q     <= d1_d;
         msg_q    <= msg_d;
         rdy_q    <= rdy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rs_d     = rs_q;
      rs_vld_d = rs_vld_q;
      d1_d     = d1_q;
      cmpl     = 1'b0;
      cmpl_msg = '0;
      if (rx_valid) begin
         if (rx_byte >= RT_MIN) begin
            state_d = state_q;
         end else if (rx_byte >= SYS) begin
            rs_d     = '0;
            rs_vld_d = 1'b0;
            state_d  = P_WAIT_STATUS;
         end else if (rx_byte >= NOTE_OFF) begin
            rs_d     = rx_byte;
            rs_vld_d = 1'b1;
            state_d  = P_WAIT_D1;
         end else if (state_q == P_WAIT_D2) begin
            cmpl     = 1'b1;
            cmpl_msg = {rs_q, d1_q, rx_byte};
            state_d  = P_WAIT_D1;
         end else if (state_q == P_WAIT_D1 || rs_vld_q) begin
            // WAIT_STATUS with a live running status behaves exactly like WAIT_D1.
            d1_d = rx_byte;
            if (is_one_data(rs_q)) begin
               cmpl     = 1'b1;
               cmpl_msg = {rs_q, rx_byte, 8'h00};
               state_d  = P_WAIT_D1;
            end else begin
               state_d  = P_WAIT_D2;
            end
         end
      end
   end

   always_comb begin
      msg_d = msg_q;
      rdy_d = 1'b0;
      if (cmpl && (OMNI || cmpl_msg[19:16] == CHANNEL)) begin
         msg_d = cmpl_msg;
         rdy_d = 1'b1;
      end
      MIDI_MSG     = msg_q;
      MIDI_MSG_RDY = rdy_q;
      RX_ERR       = rx_err;
   end

endmodule
